// File: rtl/instruction_decoder_pipe.sv
// rtl/instruction_decoder_pipe.sv - registered, flow-controlled RV32-subset decoder with skid buffer, flush and sticky halt
module instruction_decoder_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 2,
  parameter int SKID  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_op,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic [XLEN-1:0]  out_imm,
  output logic [CNT_W-1:0] out_cnt_set,
  output logic [XLEN-1:0]  out_pc,
  output logic             out_illegal,
  output logic             halted
);

  localparam logic [3:0] OP_ILL  = 4'd0,  OP_ADD = 4'd1,  OP_SUB = 4'd2,  OP_AND = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4,  OP_XOR = 4'd5,  OP_ADDI = 4'd6, OP_LW = 4'd7;
  localparam logic [3:0] OP_SW   = 4'd8,  OP_LUI = 4'd9,  OP_JAL = 4'd10, OP_BEQ = 4'd11;
  localparam logic [3:0] OP_BNE  = 4'd12;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [3:0]       op;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic [XLEN-1:0]  imm;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  pc;
    logic             illegal;
  } bundle_t;

  bundle_t dec;
  bundle_t out_q, out_d;
  bundle_t skid_q, skid_d;
  logic    out_valid_q, out_valid_d;
  logic    skid_valid_q, skid_valid_d;
  logic    halted_q, halted_d;

  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic [6:0]         funct7;
  logic [3:0]         dec_op;
  logic               use_rs1, use_rs2, use_rd;
  logic signed [31:0] imm32;
  logic               out_free, accept;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  always_comb begin
    dec_op  = OP_ILL;
    imm32   = '0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    case (opcode)
      OPC_R: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_rd  = 1'b1;
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000:  dec_op = OP_ADD;
            3'b111:  dec_op = OP_AND;
            3'b110:  dec_op = OP_OR;
            3'b100:  dec_op = OP_XOR;
            default: dec_op = OP_ILL;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          dec_op = OP_SUB;
        end
      end
      OPC_OPIMM: if (funct3 == 3'b000) begin
        dec_op  = OP_ADDI;
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
        imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      OPC_LOAD: if (funct3 == 3'b010) begin
        dec_op  = OP_LW;
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
        imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      OPC_STORE: if (funct3 == 3'b010) begin
        dec_op  = OP_SW;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      OPC_LUI: begin
        dec_op = OP_LUI;
        use_rd = 1'b1;
        imm32  = {in_instr[31:12], 12'b0};
      end
      OPC_JAL: begin
        dec_op = OP_JAL;
        use_rd = 1'b1;
        imm32  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
      end
      OPC_BRANCH: if (funct3 == 3'b000 || funct3 == 3'b001) begin
        dec_op  = (funct3 == 3'b000) ? OP_BEQ : OP_BNE;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm32   = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      end
      default: dec_op = OP_ILL;
    endcase

    dec    = '0;
    dec.pc = in_pc;
    if (dec_op == OP_ILL) begin
      dec.illegal = 1'b1;
    end else begin
      dec.op  = dec_op;
      dec.rs1 = use_rs1 ? in_instr[19:15] : 5'd0;
      dec.rs2 = use_rs2 ? in_instr[24:20] : 5'd0;
      dec.rd  = use_rd  ? in_instr[11:7]  : 5'd0;
      dec.imm = XLEN'(imm32);
      case (dec_op)
        OP_LW:                        dec.cnt = CNT_W'(3);
        OP_SW, OP_JAL, OP_BEQ, OP_BNE: dec.cnt = CNT_W'(2);
        default:                      dec.cnt = CNT_W'(1);
      endcase
    end
  end

  // With the skid present, in_ready depends only on registered state (flush aside).
  assign out_free = ~out_valid_q | out_ready;

  always_comb begin
    if (SKID != 0) begin
      in_ready = ~skid_valid_q & ~halted_q & ~flush;
    end else begin
      in_ready = out_free & ~halted_q & ~flush;
    end
  end

  assign accept = in_valid & in_ready;

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    halted_d     = halted_q | (accept & dec.illegal);
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_free) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = dec;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      halted_q     <= halted_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_op      = out_q.op;
  assign out_rs1     = out_q.rs1;
  assign out_rs2     = out_q.rs2;
  assign out_rd      = out_q.rd;
  assign out_imm     = out_q.imm;
  assign out_cnt_set = out_q.cnt;
  assign out_pc      = out_q.pc;
  assign out_illegal = out_q.illegal;
  assign halted      = halted_q;

endmodule

// File: tb/tb_instruction_decoder_pipe.sv
// tb/tb_instruction_decoder_pipe.sv - directed and randomized bench for instruction_decoder_pipe against a queue-based model
module tb_instruction_decoder_pipe;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_AND  = 32'h0020F1B3;
  localparam logic [31:0] I_OR   = 32'h0020E1B3;
  localparam logic [31:0] I_XOR  = 32'h0020C1B3;
  localparam logic [31:0] I_ADDI = 32'hFFF00293;
  localparam logic [31:0] I_SW   = 32'hFE20AE23;
  localparam logic [31:0] I_BEQ  = 32'hFE208CE3;

  localparam int CNT_TAB [0:12] = '{0, 1, 1, 1, 1, 1, 1, 3, 2, 1, 2, 2, 2};

  logic        clk, rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_imm, out_pc;
  logic [3:0]  out_op;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [1:0]  out_cnt_set;
  logic        out_illegal, halted;

  instruction_decoder_pipe #(.XLEN(32), .CNT_W(2), .SKID(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
    .out_cnt_set(out_cnt_set), .out_pc(out_pc), .out_illegal(out_illegal),
    .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic [1:0]  cnt;
    logic [31:0] pc;
    logic        ill;
  } exp_t;

  exp_t q[$];
  exp_t pend_e;
  bit   halted_m, pend_acc, pend_con, pend_flush, exp_rdy;
  int   n_pass = 0;
  int   n_total = 0;

  function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
    exp_t e;
    logic signed [31:0] s;
    int op;
    s = w;
    casez ({w[31:25], w[14:12], w[6:0]})
      17'b0000000_000_0110011: op = 1;
      17'b0100000_000_0110011: op = 2;
      17'b0000000_111_0110011: op = 3;
      17'b0000000_110_0110011: op = 4;
      17'b0000000_100_0110011: op = 5;
      17'b???????_000_0010011: op = 6;
      17'b???????_010_0000011: op = 7;
      17'b???????_010_0100011: op = 8;
      17'b???????_???_0110111: op = 9;
      17'b???????_???_1101111: op = 10;
      17'b???????_000_1100011: op = 11;
      17'b???????_001_1100011: op = 12;
      default:                 op = 0;
    endcase
    e.op  = 4'(op);
    e.ill = (op == 0);
    e.pc  = pc;
    e.rs1 = (op inside {[1:8], 11, 12}) ? w[19:15] : 5'd0;
    e.rs2 = (op inside {[1:5], 8, 11, 12}) ? w[24:20] : 5'd0;
    e.rd  = (op inside {[1:7], 9, 10}) ? w[11:7] : 5'd0;
    case (op)
      6, 7:    e.imm = 32'(s >>> 20);
      8:       e.imm = (32'(s >>> 25) << 5) | 32'(w[11:7]);
      9:       e.imm = w & 32'hFFFF_F000;
      10:      e.imm = (32'(s >>> 31) << 20) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
      11, 12:  e.imm = (32'(s >>> 31) << 12) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
      default: e.imm = 32'd0;
    endcase
    e.cnt = 2'(CNT_TAB[op]);
    return e;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 13))
      0:  begin w[31:25] = 7'b0000000; w[14:12] = 3'b000; w[6:0] = 7'b0110011; end
      1:  begin w[31:25] = 7'b0100000; w[14:12] = 3'b000; w[6:0] = 7'b0110011; end
      2:  begin w[31:25] = 7'b0000000; w[14:12] = 3'b111; w[6:0] = 7'b0110011; end
      3:  begin w[31:25] = 7'b0000000; w[14:12] = 3'b110; w[6:0] = 7'b0110011; end
      4:  begin w[31:25] = 7'b0000000; w[14:12] = 3'b100; w[6:0] = 7'b0110011; end
      5:  begin w[14:12] = 3'b000; w[6:0] = 7'b0010011; end
      6:  begin w[14:12] = 3'b010; w[6:0] = 7'b0000011; end
      7:  begin w[14:12] = 3'b010; w[6:0] = 7'b0100011; end
      8:  w[6:0] = 7'b0110111;
      9:  w[6:0] = 7'b1101111;
      10: begin w[14:12] = 3'b000; w[6:0] = 7'b1100011; end
      11: begin w[14:12] = 3'b001; w[6:0] = 7'b1100011; end
      12: w[6:0] = 7'b0110011;
      default: ;
    endcase
    return w;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_bundle(input logic [3:0] op, input logic [4:0] r1, input logic [4:0] r2,
                            input logic [4:0] rd, input logic [31:0] imm, input logic [1:0] cnt);
    chk("dir_op", out_op, op);
    chk("dir_rs1", out_rs1, r1);
    chk("dir_rs2", out_rs2, r2);
    chk("dir_rd", out_rd, rd);
    chk("dir_imm", out_imm, imm);
    chk("dir_cnt", out_cnt_set, cnt);
  endtask

  task automatic check_model();
    chk("out_valid", out_valid, q.size() > 0);
    chk("in_ready", in_ready, exp_rdy);
    chk("halted", halted, halted_m);
    if (q.size() > 0) begin
      chk("op", out_op, q[0].op);
      chk("rs1", out_rs1, q[0].rs1);
      chk("rs2", out_rs2, q[0].rs2);
      chk("rd", out_rd, q[0].rd);
      chk("imm", out_imm, q[0].imm);
      chk("cnt", out_cnt_set, q[0].cnt);
      chk("pc", out_pc, q[0].pc);
      chk("illegal", out_illegal, q[0].ill);
    end
  endtask

  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic rdy, input logic fl);
    @(posedge clk);
    if (pend_flush) begin
      q.delete();
    end else begin
      if (pend_con) void'(q.pop_front());
      if (pend_acc) begin
        q.push_back(pend_e);
        if (pend_e.ill) halted_m = 1'b1;
      end
    end
    @(negedge clk);
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = rdy;
    flush     = fl;
    #1;
    exp_rdy = (q.size() < 2) && !halted_m && !fl;
    check_model();
    pend_acc   = v && exp_rdy;
    pend_con   = (q.size() > 0) && rdy && !fl;
    pend_flush = fl;
    pend_e     = ref_decode(ins, pc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; in_instr = I_ADD; out_ready = 1'b0; flush = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    q.delete();
    halted_m = 1'b0; pend_acc = 1'b0; pend_con = 1'b0; pend_flush = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_illegal", out_illegal, 1'b0);
    chk_bundle(4'd0, 5'd0, 5'd0, 5'd0, 32'd0, 2'd0);
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    out_ready = 1'b0; flush = 1'b0;
    do_reset();

    step(1, I_ADD, 32'h0, 1, 0);
    step(0, 32'h0, 32'h0, 1, 0);
    chk_bundle(4'd1, 5'd1, 5'd2, 5'd3, 32'd0, 2'd1);
    step(1, I_ADDI, 32'h4, 1, 0);
    step(1, I_SW, 32'h8, 1, 0);
    chk_bundle(4'd6, 5'd0, 5'd0, 5'd5, 32'hFFFF_FFFF, 2'd1);
    step(1, I_BEQ, 32'h40, 1, 0);
    chk_bundle(4'd8, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFC, 2'd2);
    step(0, 32'h0, 32'h0, 1, 0);
    chk_bundle(4'd11, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFF8, 2'd2);
    chk("beq_pc", out_pc, 32'h40);

    step(1, I_ADD, 32'h100, 0, 0);
    step(1, I_ADDI, 32'h104, 0, 0);
    step(1, I_XOR, 32'h108, 0, 0);
    chk("bp_in_ready", in_ready, 1'b0);
    chk("bp_hold_op", out_op, 4'd1);
    step(0, 32'h0, 32'h0, 1, 0);
    chk("bp_first_op", out_op, 4'd1);
    step(0, 32'h0, 32'h0, 1, 0);
    chk("bp_second_op", out_op, 4'd6);
    chk("bp_ready_back", in_ready, 1'b1);
    step(0, 32'h0, 32'h0, 1, 0);

    step(1, 32'h0, 32'h200, 1, 0);
    step(1, I_ADD, 32'h204, 1, 0);
    chk_bundle(4'd0, 5'd0, 5'd0, 5'd0, 32'd0, 2'd0);
    chk("ill_flag", out_illegal, 1'b1);
    chk("ill_pc", out_pc, 32'h200);
    chk("ill_halted", halted, 1'b1);
    chk("ill_in_ready", in_ready, 1'b0);
    step(1, I_ADD, 32'h208, 1, 1);
    step(1, I_ADD, 32'h20C, 1, 0);
    chk("flush_keeps_halt", halted, 1'b1);
    do_reset();

    step(1, I_ADD, 32'h300, 0, 0);
    step(1, I_SUB, 32'h304, 0, 0);
    step(1, I_AND, 32'h308, 0, 1);
    chk("flush_in_ready", in_ready, 1'b0);
    step(0, 32'h0, 32'h0, 0, 0);
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_ready_back", in_ready, 1'b1);
    step(1, I_OR, 32'h30C, 1, 0);
    step(0, 32'h0, 32'h0, 1, 0);
    chk("post_flush_op", out_op, 4'd4);
    chk("post_flush_pc", out_pc, 32'h30C);

    step(1, I_ADD, 32'h400, 0, 0);
    step(1, I_XOR, 32'h404, 0, 0);
    do_reset();

    for (int i = 0; i < 800; i++) begin
      step(($urandom % 4) != 0, gen_instr(), $urandom, ($urandom % 3) != 0, ($urandom % 40) == 0);
      if (halted_m && q.size() == 0) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
